// File: rtl/tx_interface_pkt_fifo_if.sv
// TX interface packet FIFO bus: DLL-side write port and framer-side read port.
interface tx_interface_pkt_fifo_if #(
  parameter int DATA_WIDTH       = 256,
  parameter int DEPTH            = 16,
  parameter int PACKET_LENGTH    = 11,
  parameter int SYMBOL_PTR_WIDTH = 5,
  parameter int CNT_WIDTH        = $clog2(DEPTH + 1)
);
  // write side
  logic                        i_WR_EN;
  logic [DATA_WIDTH-1:0]       Data_IN;
  logic [SYMBOL_PTR_WIDTH-1:0] i_Last_Byte;
  logic [PACKET_LENGTH-1:0]    i_Length;
  logic                        i_SOP;
  logic                        i_End_Valid;
  logic                        i_Type;
  // read side
  logic                        i_RD_EN;
  logic [DATA_WIDTH-1:0]       Data_Out;
  logic [SYMBOL_PTR_WIDTH-1:0] o_Last_Byte;
  logic [PACKET_LENGTH-1:0]    o_Length;
  logic                        o_SOP;
  logic                        o_End_Valid;
  logic                        o_Type;
  // status
  logic                        o_Empty;
  logic                        o_Full;
  logic                        o_Almost_Full;
  logic [CNT_WIDTH-1:0]        o_Level;
  logic [CNT_WIDTH-1:0]        o_Pkt_Count;
  logic                        o_Pkt_Avail;
  logic                        o_Overflow;
  logic                        o_Underflow;

  // FIFO side
  modport slave (
    input  i_WR_EN, Data_IN, i_Last_Byte, i_Length, i_SOP, i_End_Valid, i_Type, i_RD_EN,
    output Data_Out, o_Last_Byte, o_Length, o_SOP, o_End_Valid, o_Type,
    output o_Empty, o_Full, o_Almost_Full, o_Level, o_Pkt_Count, o_Pkt_Avail,
    output o_Overflow, o_Underflow
  );

  // DLL / framer side
  modport master (
    output i_WR_EN, Data_IN, i_Last_Byte, i_Length, i_SOP, i_End_Valid, i_Type, i_RD_EN,
    input  Data_Out, o_Last_Byte, o_Length, o_SOP, o_End_Valid, o_Type,
    input  o_Empty, o_Full, o_Almost_Full, o_Level, o_Pkt_Count, o_Pkt_Avail,
    input  o_Overflow, o_Underflow
  );
endinterface

// File: rtl/tx_interface_pkt_fifo.sv
// Packet-aware show-ahead synchronous FIFO between DLL TX and the framing path.
// Arbitrary depth, occupancy/almost-full status, complete-packet count, sticky errors.
module tx_interface_pkt_fifo #(
  parameter int DATA_WIDTH       = 256,
  parameter int DEPTH            = 16,
  parameter int PACKET_LENGTH    = 11,
  parameter int SYMBOL_PTR_WIDTH = 5,
  parameter int AFULL_THRESH     = 12,
  parameter int CNT_WIDTH        = $clog2(DEPTH + 1)
) (
  input  logic                    CLK,
  input  logic                    RST_L,
  input  logic                    Soft_RST_blocks,
  tx_interface_pkt_fifo_if.slave  fifo_if
);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = DATA_WIDTH + SYMBOL_PTR_WIDTH + PACKET_LENGTH + 3;

  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] level_q, level_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  logic                 full, empty, wr_acc, rd_acc, pkt_inc, pkt_dec;
  logic [ENTRY_W-1:0]   wr_entry, head;

  // Status decode from registered state and accept qualification.
  always_comb begin
    full     = (level_q == CNT_WIDTH'(DEPTH));
    empty    = (level_q == '0);
    wr_acc   = fifo_if.i_WR_EN && !full;
    rd_acc   = fifo_if.i_RD_EN && !empty;
    head     = mem_q[rd_ptr_q];
    pkt_inc  = wr_acc && fifo_if.i_End_Valid;
    pkt_dec  = rd_acc && head[1];
    wr_entry = {fifo_if.Data_IN, fifo_if.i_Last_Byte, fifo_if.i_Length,
                fifo_if.i_SOP, fifo_if.i_End_Valid, fifo_if.i_Type};
  end

  // Next-state for pointers, level, packet count and sticky flags; soft reset wins.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    pkt_cnt_d = pkt_cnt_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    if (Soft_RST_blocks) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      pkt_cnt_d = '0;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      case ({pkt_inc, pkt_dec})
        2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
        2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
        default: pkt_cnt_d = pkt_cnt_q;
      endcase
      if (fifo_if.i_WR_EN && full)  ovf_d = 1'b1;
      if (fifo_if.i_RD_EN && empty) unf_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      pkt_cnt_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      pkt_cnt_q <= pkt_cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Entry storage, intentionally not reset.
  always_ff @(posedge CLK) begin
    if (wr_acc && !Soft_RST_blocks) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Head presentation (zeroed while empty) and status outputs.
  always_comb begin
    {fifo_if.Data_Out, fifo_if.o_Last_Byte, fifo_if.o_Length,
     fifo_if.o_SOP, fifo_if.o_End_Valid, fifo_if.o_Type} = empty ? '0 : head;
    fifo_if.o_Empty       = empty;
    fifo_if.o_Full        = full;
    fifo_if.o_Almost_Full = (level_q >= CNT_WIDTH'(AFULL_THRESH));
    fifo_if.o_Level       = level_q;
    fifo_if.o_Pkt_Count   = pkt_cnt_q;
    fifo_if.o_Pkt_Avail   = (pkt_cnt_q != '0);
    fifo_if.o_Overflow    = ovf_q;
    fifo_if.o_Underflow   = unf_q;
  end
endmodule

// File: tb/tb_tx_interface_pkt_fifo.sv
// Directed bench for tx_interface_pkt_fifo: a 16-deep instance and a 13-deep instance.
module tb_tx_interface_pkt_fifo;
  logic CLK = 1'b0;
  logic RST_L = 1'b1;
  logic soft_a = 1'b0;
  logic soft_b = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;

  tx_interface_pkt_fifo_if #(.DATA_WIDTH(256), .DEPTH(16)) fa ();
  tx_interface_pkt_fifo_if #(.DATA_WIDTH(32),  .DEPTH(13)) fb ();

  tx_interface_pkt_fifo #(.DATA_WIDTH(256), .DEPTH(16), .AFULL_THRESH(12)) dut_a (
    .CLK(CLK), .RST_L(RST_L), .Soft_RST_blocks(soft_a), .fifo_if(fa));
  tx_interface_pkt_fifo #(.DATA_WIDTH(32), .DEPTH(13), .AFULL_THRESH(10)) dut_b (
    .CLK(CLK), .RST_L(RST_L), .Soft_RST_blocks(soft_b), .fifo_if(fb));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr_a(input logic [255:0] d);
    fa.i_WR_EN = 1'b1; fa.Data_IN = d;
    tick();
    fa.i_WR_EN = 1'b0;
  endtask

  logic [31:0] q[$];
  int          written;
  int          cyc;
  logic        do_wr, do_rd;

  initial begin
    fa.i_WR_EN = 0; fa.Data_IN = '0; fa.i_Last_Byte = '0; fa.i_Length = '0;
    fa.i_SOP = 0; fa.i_End_Valid = 0; fa.i_Type = 0; fa.i_RD_EN = 0;
    fb.i_WR_EN = 0; fb.Data_IN = '0; fb.i_Last_Byte = '0; fb.i_Length = '0;
    fb.i_SOP = 0; fb.i_End_Valid = 0; fb.i_Type = 0; fb.i_RD_EN = 0;

    // asynchronous reset
    #1 RST_L = 1'b0;
    #12;
    chk("rst_empty", fa.o_Empty, 1);
    chk("rst_full", fa.o_Full, 0);
    chk("rst_afull", fa.o_Almost_Full, 0);
    chk("rst_level", fa.o_Level, 0);
    chk("rst_pkt", fa.o_Pkt_Count, 0);
    chk("rst_avail", fa.o_Pkt_Avail, 0);
    chk("rst_ovf", fa.o_Overflow, 0);
    chk("rst_unf", fa.o_Underflow, 0);
    chk("rst_data", fa.Data_Out, 0);
    chk("rst_b_empty", fb.o_Empty, 1);
    @(negedge CLK) RST_L = 1'b1;
    tick();

    // fill 16
    for (int i = 0; i < 16; i++) begin
      wr_a(256'(i));
      chk("fill_level", fa.o_Level, i + 1);
      chk("fill_afull", fa.o_Almost_Full, (i + 1) >= 12);
      chk("fill_full", fa.o_Full, (i + 1) == 16);
    end
    chk("fill_head", fa.Data_Out, 0);

    // overflow
    wr_a(256'd99);
    chk("ovf_level", fa.o_Level, 16);
    chk("ovf_flag", fa.o_Overflow, 1);
    tick();
    chk("ovf_sticky", fa.o_Overflow, 1);

    // drain
    fa.i_RD_EN = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", fa.Data_Out, 256'(i));
      tick();
    end
    fa.i_RD_EN = 1'b0;
    chk("drain_empty", fa.o_Empty, 1);
    chk("drain_head0", fa.Data_Out, 0);
    chk("drain_unf", fa.o_Underflow, 0);

    // full boundary: both high -> read only
    for (int i = 0; i < 16; i++) wr_a(256'(100 + i));
    fa.i_WR_EN = 1'b1; fa.i_RD_EN = 1'b1; fa.Data_IN = 256'd200;
    tick();
    fa.i_WR_EN = 1'b0; fa.i_RD_EN = 1'b0;
    chk("fullrw_level", fa.o_Level, 15);
    fa.i_RD_EN = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("fullrw_data", fa.Data_Out, 256'(100 + i));
      tick();
    end
    fa.i_RD_EN = 1'b0;
    chk("fullrw_empty", fa.o_Empty, 1);

    // empty boundary: both high -> write only
    fa.i_WR_EN = 1'b1; fa.i_RD_EN = 1'b1; fa.Data_IN = 256'd300;
    tick();
    fa.i_WR_EN = 1'b0; fa.i_RD_EN = 1'b0;
    chk("emptyrw_level", fa.o_Level, 1);
    chk("emptyrw_head", fa.Data_Out, 256'd300);
    chk("emptyrw_unf", fa.o_Underflow, 1);

    // level 5, both high -> unchanged
    for (int i = 1; i < 5; i++) wr_a(256'(300 + i));
    chk("mid_level5", fa.o_Level, 5);
    fa.i_WR_EN = 1'b1; fa.i_RD_EN = 1'b1; fa.Data_IN = 256'd305;
    tick();
    fa.i_WR_EN = 1'b0; fa.i_RD_EN = 1'b0;
    chk("midrw_level", fa.o_Level, 5);
    fa.i_RD_EN = 1'b1;
    for (int i = 1; i < 6; i++) begin
      chk("midrw_data", fa.Data_Out, 256'(300 + i));
      tick();
    end
    fa.i_RD_EN = 1'b0;
    chk("midrw_empty", fa.o_Empty, 1);

    // packets of 3, 1, 2 entries
    for (int i = 0; i < 6; i++) begin
      fa.i_SOP       = (i == 0) || (i == 3) || (i == 4);
      fa.i_End_Valid = (i == 2) || (i == 3) || (i == 5);
      fa.i_Type      = i[0];
      fa.i_Length    = 11'(i * 7);
      fa.i_Last_Byte = 5'(i + 3);
      wr_a(256'(400 + i));
    end
    fa.i_SOP = 0; fa.i_End_Valid = 0; fa.i_Type = 0; fa.i_Length = '0; fa.i_Last_Byte = '0;
    chk("pkt_count3", fa.o_Pkt_Count, 3);
    chk("pkt_avail", fa.o_Pkt_Avail, 1);
    chk("pkt_head_sop", fa.o_SOP, 1);
    chk("pkt_head_ev", fa.o_End_Valid, 0);
    fa.i_RD_EN = 1'b1;
    tick();
    chk("pkt_len1", fa.o_Length, 7);
    chk("pkt_lb1", fa.o_Last_Byte, 4);
    chk("pkt_type1", fa.o_Type, 1);
    tick();
    chk("pkt_ev2", fa.o_End_Valid, 1);
    tick();
    chk("pkt_count2", fa.o_Pkt_Count, 2);
    chk("pkt_head3", fa.Data_Out, 256'd403);
    tick();
    chk("pkt_count1", fa.o_Pkt_Count, 1);
    tick();
    chk("pkt_avail_last", fa.o_Pkt_Avail, 1);
    tick();
    fa.i_RD_EN = 1'b0;
    chk("pkt_count0", fa.o_Pkt_Count, 0);
    chk("pkt_avail0", fa.o_Pkt_Avail, 0);
    chk("pkt_empty_ev", fa.o_End_Valid, 0);

    // soft reset mid-stream
    for (int i = 0; i < 7; i++) wr_a(256'(500 + i));
    chk("soft_pre_level", fa.o_Level, 7);
    chk("soft_pre_unf", fa.o_Underflow, 1);
    soft_a = 1'b1; fa.i_WR_EN = 1'b1; fa.Data_IN = 256'd999;
    tick();
    soft_a = 1'b0; fa.i_WR_EN = 1'b0;
    chk("soft_level", fa.o_Level, 0);
    chk("soft_empty", fa.o_Empty, 1);
    chk("soft_ovf", fa.o_Overflow, 0);
    chk("soft_unf", fa.o_Underflow, 0);
    chk("soft_head", fa.Data_Out, 0);
    wr_a(256'd555);
    chk("soft_after_level", fa.o_Level, 1);
    chk("soft_after_data", fa.Data_Out, 256'd555);

    // DEPTH=13: fill to full, then random interleave, 40 writes total
    written = 0;
    for (int i = 0; i < 13; i++) begin
      fb.i_WR_EN = 1'b1; fb.Data_IN = 32'(1000 + written);
      q.push_back(32'(1000 + written));
      written++;
      tick();
      chk("b_fill_full", fb.o_Full, (i == 12));
      chk("b_fill_afull", fb.o_Almost_Full, (i + 1) >= 10);
    end
    fb.i_WR_EN = 1'b0;
    chk("b_level13", fb.o_Level, 13);
    cyc = 0;
    while ((written < 40 || q.size() != 0) && cyc < 2000) begin
      do_wr = (written < 40) && (q.size() < 13) && ($urandom_range(0, 2) != 0);
      do_rd = (q.size() != 0) && ($urandom_range(0, 1) != 0);
      fb.i_WR_EN = do_wr; fb.Data_IN = 32'(1000 + written);
      fb.i_RD_EN = do_rd;
      if (do_rd) chk("b_data", fb.Data_Out, q[0]);
      tick();
      if (do_rd) void'(q.pop_front());
      if (do_wr) begin
        q.push_back(32'(1000 + written));
        written++;
      end
      chk("b_level", fb.o_Level, q.size());
      chk("b_full", fb.o_Full, q.size() == 13);
      cyc++;
    end
    fb.i_WR_EN = 1'b0; fb.i_RD_EN = 1'b0;
    chk("b_done_in_budget", (cyc < 2000), 1);
    chk("b_final_empty", fb.o_Empty, 1);
    chk("b_no_errors", {fb.o_Overflow, fb.o_Underflow}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tx_interface_pkt_fifo.md
# tx_interface_pkt_fifo

Parametrised, packet-aware synchronous FIFO between the DLL transmit interface and the TX framing/128b-130b path. It decouples DLL flow from PHY stalls (ordered-set/SKP insertion, framing-token insertion, encoding halts). It generalises the fixed 16-deep TX interface buffer with:
- arbitrary (non-power-of-two) depth;
- an occupancy count and a programmable almost-full threshold for early DLL back-pressure;
- a complete-packet counter, so the framer starts a packet only when its end is already buffered;
- sticky overflow/underflow error flags.

## Interface
Parameters:
- DATA_WIDTH, 256, data bits per entry (32 symbols).
- DEPTH, 16, number of entries; any value >= 2, power of two not required.
- PACKET_LENGTH, 11, width of the packet length field (DW).
- SYMBOL_PTR_WIDTH, 5, width of the last-valid-byte pointer.
- AFULL_THRESH, 12, o_Almost_Full asserts when level >= this value; legal range 1..DEPTH.
- CNT_WIDTH, $clog2(DEPTH+1), derived; width of the level and packet counters.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_L  in  1  asynchronous, active-low reset.
- Soft_RST_blocks  in  1  synchronous flush; active high.
- i_WR_EN  in  1  write request.
- Data_IN  in  DATA_WIDTH  write data, bit 0 = first symbol.
- i_Last_Byte  in  SYMBOL_PTR_WIDTH  last valid byte index of the entry.
- i_Length  in  PACKET_LENGTH  packet length (DW).
- i_SOP, i_End_Valid, i_Type  in  1 each  start-of-packet, end-of-packet, packet type (TLP/DLLP).
- i_RD_EN  in  1  pop request for the head entry.
- Data_Out, o_Last_Byte, o_Length, o_SOP, o_End_Valid, o_Type  out  as inputs  head entry (show-ahead).
- o_Empty, o_Full, o_Almost_Full  out  1 each  status.
- o_Level  out  CNT_WIDTH  entries stored.
- o_Pkt_Count  out  CNT_WIDTH  stored entries with End_Valid=1.
- o_Pkt_Avail  out  1  o_Pkt_Count != 0.
- o_Overflow, o_Underflow  out  1 each  sticky error flags.

## Operation
- **Storage:** DEPTH entries, each {data, last_byte, length, SOP, End_Valid, Type}. Storage is not reset.
- **Pointers:** wr_ptr and rd_ptr, range 0..DEPTH-1. Each increments on its accepted operation and wraps DEPTH-1 -> 0. A level register tracks occupancy, range 0..DEPTH.
- **Status:** o_Full = (level == DEPTH); o_Empty = (level == 0). Both are decoded from registered state only.
- **Accept rules:**
  - Write is accepted iff i_WR_EN && !o_Full.
  - Read is accepted iff i_RD_EN && !o_Empty.
  - Fullness and emptiness are evaluated on pre-edge state. When full, a simultaneous read and write accepts only the read. When empty, only the write is accepted.
- **Level update:** +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- **Packet counter:**
  - +1 on an accepted write with i_End_Valid=1.
  - -1 on an accepted read whose head o_End_Valid=1.
  - Net zero when both happen in the same cycle.
- **Almost full:** o_Almost_Full = (level >= AFULL_THRESH).
- **Head outputs:** combinational from the rd_ptr entry while !o_Empty. All head outputs are forced to 0 while o_Empty=1.
- **Error flags:**
  - o_Overflow sets on i_WR_EN && o_Full.
  - o_Underflow sets on i_RD_EN && o_Empty.
  - Both hold until RST_L or Soft_RST_blocks clears them.
- **Soft reset:** Soft_RST_blocks has priority over reads and writes in the same cycle. It zeroes the pointers, level, packet count and both flags. Storage contents are left stale but unobservable.

## Timing
- **Reset values (RST_L low, asynchronous):**
  - o_Empty=1; o_Full=0; o_Almost_Full=0.
  - o_Level=0; o_Pkt_Count=0; o_Pkt_Avail=0.
  - o_Overflow=0; o_Underflow=0.
  - All head outputs 0.
- **Write-to-read latency:** an entry written at edge N appears on the head outputs, with o_Empty=0, in the cycle after edge N. There is no bypass from Data_IN in the same cycle.
- **Status timing:** status, level and counters change only at clock edges. Status never depends combinationally on i_WR_EN or i_RD_EN.
- **Pop timing:** after an accepted read at edge N, the next entry (or zeros if the FIFO became empty) is presented in the following cycle.
- **Throughput:** one write and one read per cycle, sustained at any level 1..DEPTH-1.
- **Soft-reset recovery:** one cycle; a write in the next cycle is accepted normally.

## Test plan
- **Reset and fill:** reset, then write 16 entries with Data_IN = index, one per cycle -> o_Level steps 1..16; o_Almost_Full rises in the cycle after the 12th write; o_Full=1 after the 16th; head shows index 0.
- **Overflow:** 17th write while full, with i_RD_EN=0 -> entry dropped; o_Level stays 16; o_Overflow=1 and stays set. Then drain 16 reads -> data 0..15 in order; o_Empty=1; head outputs 0.
- **Full-boundary simultaneous ops:**
  - Full, with i_WR_EN=i_RD_EN=1 -> read only; o_Level=15.
  - Then empty, with both high -> write only; o_Level=1.
  - At level 5, with both high -> o_Level stays 5.
  - Data order preserved in all three cases.
- **Non-power-of-two wrap:** DEPTH=13, AFULL_THRESH=10, 40 writes interleaved with reads at a random ratio -> data order intact across wraps; o_Full exactly at 13 entries.
- **Packet counter:** write packets of 3, 1 and 2 entries, End_Valid on each last entry -> o_Pkt_Count=3. Pop 3 entries -> 2; o_Pkt_Avail stays 1 until the final End_Valid entry is popped.
- **Soft reset mid-stream:** level 7, o_Underflow set, Soft_RST_blocks asserted with i_WR_EN=1 -> next cycle o_Level=0, o_Empty=1, flags 0, write ignored; a subsequent write is read back correctly.
